mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Shares the single unified memory port between the I-cache fill FSM and the D-cache, which issues fill requests and write-through word writes. The block grants one requester at a time and issues the 8 sequential word reads of a 16-byte block. It counts the in-order read returns and routes `mem_data_valid` to the owning cache, then pulses a done strobe. It sits between both cache fill controllers and the memory model, and its grant outputs double as stall sources.

## Interface
- `LAT`, 4, memory read latency in cycles from issue to `mem_data_valid`; legal range 1..7.
- `clk` in 1: the only clock; all state changes on its rising edge.
- `rst_n` in 1: one clock; reset is synchronous and active-high.
- `i_req` in 1: I-cache fill request; held high until `i_done`.
- `i_addr` in 16: I-cache miss byte address; block base is `i_addr[15:4]`.
- `d_req` in 1: D-cache fill request; held high until `d_done`.
- `d_wr` in 1: D-cache single-word write request; held high until `d_done`.
- `d_addr` in 16: D-cache fill or write byte address.
- `d_wdata` in 16: write data.
- `mem_data` in 16: read data from memory.
- `mem_data_valid` in 1: read data valid; returns are in issue order.
- `i_grant`, `d_grant` out 1: the owner is busy in a transaction. At most one is high.
- `i_data_valid`, `d_data_valid` out 1: `mem_data_valid` gated to the owner.
- `rd_data` out 16: `mem_data` passed through.
- `rd_offset` out 3: word index of the current return.
- `i_done`, `d_done` out 1: one-cycle completion pulses.
- `mem_en` out 1: memory access this cycle.
- `mem_wr` out 1: the access is a write.
- `mem_addr` out 16: access byte address.
- `mem_wdata` out 16: write data.

## Operation
- States:
  - IDLE: arbitrate.
  - ISSUE: issue read words 0..7.
  - DRAIN: wait for the remaining returns.
  - WRITE: one write cycle.
- Arbitration in IDLE:
  - `d_wr` has highest priority.
  - Fills: the I fill and D fill alternate by round-robin on the `last_fill` owner register; the loser wins the next tie.
  - A request seen alone always wins.
- Capture on grant: latch the owner and the block base `addr[15:4]` (or the full `d_addr` and `d_wdata` for a write).
- ISSUE:
  - Assert `mem_en=1`, `mem_wr=0`, `mem_addr={base,issue_cnt,1'b0}`.
  - `issue_cnt` increments each cycle.
  - After word 7, go to DRAIN. If the 8th return arrives in the same cycle as word 7 issues, go straight to IDLE.
- Return counting: each `mem_data_valid` while in ISSUE or DRAIN increments `ret_cnt`.
  - `rd_offset=ret_cnt` for that return.
  - The owner's data_valid is high.
- Completion: the owner's done pulses in the cycle of the 8th return. The state is IDLE on the next cycle.
- WRITE:
  - Assert `mem_en=1`, `mem_wr=1`, `mem_addr=d_addr`, `mem_wdata=d_wdata`.
  - `d_done=1` in the same cycle, then IDLE.
- Requester rules:
  - A requester samples done and drops its request before the next IDLE cycle.
  - A request that drops mid-fill does not abort the fill; it completes.
- `mem_data_valid` outside ISSUE and DRAIN, or beyond 8 returns, is ignored: no data_valid, counters do not move.
- Reset values:
  - State IDLE, counters 0, `last_fill`=D (the first tie goes to I).
  - All outputs 0; `mem_addr`, `mem_wdata`, `rd_offset` = 0.
- Reset mid-fill aborts the fill. Returns still in flight after reset are ignored as stray valids.

## Timing
- A request high in IDLE at cycle t:
  - Grant is high from t+1.
  - Words 0..7 issue at t+1..t+8.
  - Returns arrive at t+1+LAT..t+8+LAT.
  - Done pulses at t+8+LAT.
  - IDLE at t+9+LAT.
- A fill occupies the port for 9+LAT cycles including the arbitration cycle.
- Write: request at t, `mem_en`/`mem_wr` and `d_done` at t+1, IDLE at t+2.
- Grant outputs and `mem_*` derive from registered state and counters only. data_valid, `rd_data` and `rd_offset` are combinational from `mem_data_valid`.
- Back-to-back: a second pending request is granted in the IDLE cycle after done, with no extra bubble.

## Structure
- `mem_arb_pkg`: state enum (IDLE, ISSUE, DRAIN, WRITE), `BLK_WORDS=8`, `OWNER_I=1'b0`, `OWNER_D=1'b1`.
- Sub-module `blk_word_counter`:
  - 3-bit counter with `clr`, `inc`, and a `last` flag.
  - Instantiated twice, for `issue_cnt` and `ret_cnt`.

## Test plan
- `i_req`, `i_addr=16'h1234`, LAT=4:
  - `mem_addr` = 1230,1232,..,123E over 8 cycles.
  - `i_data_valid` 8 times with `rd_offset` 0..7.
  - `i_done` at t+12, `d_grant` never high.
- `i_req` and `d_req` together, repeated three times from reset: owners I, D, I.
- `d_wr`, `d_req` and `i_req` together: WRITE first (`mem_wr=1`, `d_done` at t+1), then the I fill, then the D fill.
- Stray `mem_data_valid` in IDLE and a 9th return after completion: no data_valid, counters unchanged.
- `rst_n` high in the middle of a D fill after 3 returns:
  - IDLE next cycle, all outputs 0.
  - Late returns ignored.
  - The next `i_req` completes a normal 8-word fill.
- LAT=1: the return overlaps issue; done is high 9 cycles after the request; no return is lost.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// mem_arb_pkg: shared types and constants for the unified memory-port arbiter.
//   arb_state_t  : arbiter FSM states
//   BLK_WORDS    : 16-bit words per 16-byte cache block
//   OWNER_I/D    : encoding of the owner and round-robin registers
//   word_addr()  : byte address of word idx within a block base
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        WRITE = 2'd3
    } arb_state_t;

    localparam int   BLK_WORDS = 8;
    localparam logic OWNER_I   = 1'b0;
    localparam logic OWNER_D   = 1'b1;

    function automatic logic [15:0] word_addr(input logic [11:0] base,
                                              input logic [2:0]  idx);
        return {base, idx, 1'b0};
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: every signal between the arbiter, the two cache fill
// controllers and the memory model.
//   master modport : the arbiter (takes requests and read returns, drives
//                    grants, data_valid/done strobes and the memory port)
//   slave modport  : the surrounding caches and memory
interface mem_arbiter_if;

    // requesters
    logic        i_req;
    logic [15:0] i_addr;
    logic        d_req;
    logic        d_wr;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;

    // responses to requesters
    logic        i_grant;
    logic        d_grant;
    logic        i_data_valid;
    logic        d_data_valid;
    logic [15:0] rd_data;
    logic [2:0]  rd_offset;
    logic        i_done;
    logic        d_done;

    // memory port
    logic        mem_en;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_data;
    logic        mem_data_valid;

    modport master (
        input  i_req, i_addr, d_req, d_wr, d_addr, d_wdata,
        input  mem_data, mem_data_valid,
        output i_grant, d_grant, i_data_valid, d_data_valid,
        output rd_data, rd_offset, i_done, d_done,
        output mem_en, mem_wr, mem_addr, mem_wdata
    );

    modport slave (
        output i_req, i_addr, d_req, d_wr, d_addr, d_wdata,
        output mem_data, mem_data_valid,
        input  i_grant, d_grant, i_data_valid, d_data_valid,
        input  rd_data, rd_offset, i_done, d_done,
        input  mem_en, mem_wr, mem_addr, mem_wdata
    );

endinterface

// File: rtl/mem_arbiter_counter.sv
// blk_word_counter: word index counter for one 8-word block transfer.
//   clk, srst : clock and synchronous active-high reset
//   clr       : return to 0 (takes precedence over inc)
//   inc       : advance by one; wraps to 0 after the last word
//   count     : current word index
//   last      : count is the final word of the block
module blk_word_counter
    import mem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       srst,
    input  logic       clr,
    input  logic       inc,
    output logic [2:0] count,
    output logic       last
);

    logic [2:0] count_reg;

    always_ff @(posedge clk) begin
        if (srst || clr) begin
            count_reg <= '0;
        end else if (inc) begin
            count_reg <= count_reg + 3'd1;
        end
    end

    assign count = count_reg;
    assign last  = (count_reg == 3'(BLK_WORDS - 1));

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the unified memory port between the I-cache fill FSM
// and the D-cache (fills and write-through word writes).
//   LAT   : memory read latency, 1..7 cycles (the return count, not LAT,
//           decides completion, so LAT only bounds the legal range)
//   clk   : clock
//   rst_n : synchronous reset, active HIGH despite the name
//   bus   : mem_arbiter_if.master - requests, grants, data_valid/done
//           strobes, read return routing and the memory port
// A fill issues 8 sequential word reads, counts the in-order returns and
// pulses the owner's done on the 8th. A D write is a single WRITE cycle.
// Grants and mem_* come from registered state only; the return path
// (data_valid, rd_data, rd_offset, fill done) is combinational from
// mem_data_valid.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int LAT = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_arbiter_if.master bus
);

    if (LAT < 1 || LAT > 7) begin : g_lat_check
        $error("mem_arbiter: LAT must be in 1..7");
    end

    arb_state_t  state_reg, state_next;
    logic        owner_reg;
    logic        last_fill_reg;
    logic [11:0] base_reg;
    logic [15:0] waddr_reg;
    logic [15:0] wdata_reg;

    logic        win_owner;
    logic        fill_req;
    logic        ret_ok;
    logic        fill_done;

    // Only the block base of the I-cache address is needed.
    logic unused_i_addr;
    assign unused_i_addr = ^bus.i_addr[3:0];

    // ------------------------------------------------------------------
    // Word counters: index 0 counts issued reads, index 1 counts returns.
    // Both are held at 0 while idle so a reset or a stray valid can never
    // leave a stale count for the next fill.
    // ------------------------------------------------------------------
    logic [1:0] cnt_clr;
    logic [1:0] cnt_inc;
    logic [1:0] cnt_last;
    logic [2:0] cnt_val [2];

    assign cnt_clr[0] = (state_reg == IDLE);
    assign cnt_clr[1] = (state_reg == IDLE);
    assign cnt_inc[0] = (state_reg == ISSUE);
    assign cnt_inc[1] = ret_ok;

    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
        blk_word_counter u_cnt (
            .clk   (clk),
            .srst  (rst_n),
            .clr   (cnt_clr[gi]),
            .inc   (cnt_inc[gi]),
            .count (cnt_val[gi]),
            .last  (cnt_last[gi])
        );
    end

    logic [2:0] issue_cnt;
    logic [2:0] ret_cnt;
    logic       issue_last;
    logic       ret_last;

    assign issue_cnt  = cnt_val[0];
    assign ret_cnt    = cnt_val[1];
    assign issue_last = cnt_last[0];
    assign ret_last   = cnt_last[1];

    // A return counts only while a fill is outstanding; the FSM leaves
    // ISSUE/DRAIN on the 8th, so a 9th valid lands in IDLE and is dropped.
    assign ret_ok    = bus.mem_data_valid &&
                       ((state_reg == ISSUE) || (state_reg == DRAIN));
    assign fill_done = ret_ok && ret_last;
    assign fill_req  = bus.i_req || bus.d_req;

    // Fill arbitration: a lone request wins; on a tie the owner that did
    // not take the previous fill goes next.
    always_comb begin
        win_owner = OWNER_I;
        if (bus.i_req && bus.d_req) begin
            win_owner = (last_fill_reg == OWNER_D) ? OWNER_I : OWNER_D;
        end else if (bus.d_req) begin
            win_owner = OWNER_D;
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (bus.d_wr) begin
                    state_next = WRITE;
                end else if (fill_req) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                // The 8th return can only coincide with the last issue
                // when the return path is zero-latency; handle it anyway.
                if (issue_last) begin
                    state_next = fill_done ? IDLE : DRAIN;
                end
            end
            DRAIN: begin
                if (fill_done) begin
                    state_next = IDLE;
                end
            end
            WRITE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Transaction capture at grant time
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst_n) begin
            owner_reg     <= OWNER_I;
            last_fill_reg <= OWNER_D;
            base_reg      <= '0;
            waddr_reg     <= '0;
            wdata_reg     <= '0;
        end else if (state_reg == IDLE) begin
            if (bus.d_wr) begin
                owner_reg <= OWNER_D;
                waddr_reg <= bus.d_addr;
                wdata_reg <= bus.d_wdata;
            end else if (fill_req) begin
                owner_reg     <= win_owner;
                last_fill_reg <= win_owner;
                base_reg      <= (win_owner == OWNER_D) ? bus.d_addr[15:4]
                                                        : bus.i_addr[15:4];
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        bus.i_grant      = 1'b0;
        bus.d_grant      = 1'b0;
        bus.i_data_valid = 1'b0;
        bus.d_data_valid = 1'b0;
        bus.rd_data      = '0;
        bus.rd_offset    = '0;
        bus.i_done       = 1'b0;
        bus.d_done       = 1'b0;
        bus.mem_en       = 1'b0;
        bus.mem_wr       = 1'b0;
        bus.mem_addr     = '0;
        bus.mem_wdata    = '0;

        if (state_reg != IDLE) begin
            bus.i_grant = (owner_reg == OWNER_I);
            bus.d_grant = (owner_reg == OWNER_D);
        end

        case (state_reg)
            ISSUE: begin
                bus.mem_en   = 1'b1;
                bus.mem_addr = word_addr(base_reg, issue_cnt);
            end
            WRITE: begin
                bus.mem_en    = 1'b1;
                bus.mem_wr    = 1'b1;
                bus.mem_addr  = waddr_reg;
                bus.mem_wdata = wdata_reg;
                bus.d_done    = 1'b1;
            end
            default: begin
            end
        endcase

        if (ret_ok) begin
            bus.rd_data      = bus.mem_data;
            bus.rd_offset    = ret_cnt;
            bus.i_data_valid = (owner_reg == OWNER_I);
            bus.d_data_valid = (owner_reg == OWNER_D);
            bus.i_done       = fill_done && (owner_reg == OWNER_I);
            bus.d_done       = fill_done && (owner_reg == OWNER_D);
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter. dut_a runs with LAT=4,
// dut_b with LAT=1. Each has a small fixed-latency memory model returning
// addr ^ 16'hA5A5, plus an injection path for stray read valids.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    logic clk = 1'b0;
    logic rst_a = 1'b0;
    logic rst_b = 1'b0;
    always #5 clk = ~clk;

    mem_arbiter_if if_a ();
    mem_arbiter_if if_b ();

    mem_arbiter #(.LAT(4)) dut_a (.clk(clk), .rst_n(rst_a), .bus(if_a));
    mem_arbiter #(.LAT(1)) dut_b (.clk(clk), .rst_n(rst_b), .bus(if_b));

    // memory models
    logic [7:0]       vp_a = '0;
    logic [7:0]       vp_b = '0;
    logic [7:0][15:0] ap_a = '0;
    logic [7:0][15:0] ap_b = '0;
    logic             inj_a = 1'b0;
    logic [15:0]      inj_data = 16'h7777;

    always @(posedge clk) begin
        vp_a <= {vp_a[6:0], if_a.mem_en && !if_a.mem_wr};
        ap_a <= {ap_a[6:0], if_a.mem_addr};
        vp_b <= {vp_b[6:0], if_b.mem_en && !if_b.mem_wr};
        ap_b <= {ap_b[6:0], if_b.mem_addr};
    end

    assign if_a.mem_data_valid = vp_a[3] | inj_a;
    assign if_a.mem_data       = vp_a[3] ? (ap_a[3] ^ 16'hA5A5) : inj_data;
    assign if_b.mem_data_valid = vp_b[0];
    assign if_b.mem_data       = ap_b[0] ^ 16'hA5A5;

    int checks = 0;
    int errors = 0;

    // snapshot: {i_grant,d_grant,mem_en,mem_wr,i_dv,d_dv,i_done,d_done}
    logic [7:0]  s_flags;
    logic [15:0] s_addr, s_wdata, s_data;
    logic [2:0]  s_off;

    task automatic sample(input bit sel);
        if (!sel) begin
            s_flags = {if_a.i_grant, if_a.d_grant, if_a.mem_en, if_a.mem_wr,
                       if_a.i_data_valid, if_a.d_data_valid, if_a.i_done, if_a.d_done};
            s_addr = if_a.mem_addr; s_wdata = if_a.mem_wdata;
            s_data = if_a.rd_data;  s_off   = if_a.rd_offset;
        end else begin
            s_flags = {if_b.i_grant, if_b.d_grant, if_b.mem_en, if_b.mem_wr,
                       if_b.i_data_valid, if_b.d_data_valid, if_b.i_done, if_b.d_done};
            s_addr = if_b.mem_addr; s_wdata = if_b.mem_wdata;
            s_data = if_b.rd_data;  s_off   = if_b.rd_offset;
        end
    endtask

    // Checks that every output is 0 right now.
    task automatic check_idle(input bit sel, input string name);
        sample(sel);
        checks += 4;
        if (s_flags !== 8'h00) begin
            errors++; $display("FAIL %s flags got %b want 00000000", name, s_flags);
        end
        if (s_addr !== 16'h0 || s_wdata !== 16'h0) begin
            errors++; $display("FAIL %s mem_addr/wdata got %h/%h want 0000/0000", name, s_addr, s_wdata);
        end
        if (s_off !== 3'd0) begin
            errors++; $display("FAIL %s rd_offset got %0d want 0", name, s_off);
        end
        if (s_data !== 16'h0) begin
            errors++; $display("FAIL %s rd_data got %h want 0000", name, s_data);
        end
    endtask

    // Called at the falling edge of the arbitration cycle t; checks cycles
    // t+1..t+8+lat of a fill, then drops the owner's request on its done.
    task automatic check_fill(input bit sel, input bit owner,
                              input logic [11:0] base, input int lat, input string name);
        logic [7:0]  ef;
        logic [15:0] ea, ed;
        logic [2:0]  eo;
        int          off;
        for (int k = 1; k <= 8 + lat; k++) begin
            @(negedge clk);
            sample(sel);
            off = k - 1 - lat;
            ef = 8'h00;
            if (owner == OWNER_I) ef[7] = 1'b1; else ef[6] = 1'b1;
            ef[5] = (k <= 8);
            ea = (k <= 8) ? {base, 3'(k - 1), 1'b0} : 16'h0;
            eo = 3'd0;
            ed = 16'h0;
            if (off >= 0) begin
                if (owner == OWNER_I) ef[3] = 1'b1; else ef[2] = 1'b1;
                eo = 3'(off);
                ed = {base, 3'(off), 1'b0} ^ 16'hA5A5;
            end
            if (k == 8 + lat) begin
                if (owner == OWNER_I) ef[1] = 1'b1; else ef[0] = 1'b1;
            end
            checks += 4;
            if (s_flags !== ef) begin
                errors++; $display("FAIL %s cyc%0d flags got %b want %b", name, k, s_flags, ef);
            end
            if (s_addr !== ea) begin
                errors++; $display("FAIL %s cyc%0d mem_addr got %h want %h", name, k, s_addr, ea);
            end
            if (s_off !== eo) begin
                errors++; $display("FAIL %s cyc%0d rd_offset got %0d want %0d", name, k, s_off, eo);
            end
            if (s_data !== ed) begin
                errors++; $display("FAIL %s cyc%0d rd_data got %h want %h", name, k, s_data, ed);
            end
        end
        $display("fill %s: owner=%s base=%h done after %0d cycles", name,
                 owner ? "D" : "I", base, 8 + lat);
        if (!sel) begin
            if (owner == OWNER_I) if_a.i_req = 1'b0; else if_a.d_req = 1'b0;
        end else begin
            if (owner == OWNER_I) if_b.i_req = 1'b0; else if_b.d_req = 1'b0;
        end
    endtask

    task automatic reset_dut(input bit sel);
        @(negedge clk);
        if (!sel) rst_a = 1'b1; else rst_b = 1'b1;
        repeat (2) @(negedge clk);
        if (!sel) rst_a = 1'b0; else rst_b = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_a = 1'b1; rst_b = 1'b1;
        repeat (2) @(negedge clk);
        check_idle(0, "reset_a");
        check_idle(1, "reset_b");
        rst_a = 1'b0; rst_b = 1'b0;
        @(negedge clk);
        check_idle(0, "post_reset_a");
        $display("reset: outputs checked");
    endtask

    task automatic test_i_fill();
        @(negedge clk);
        if_a.i_req = 1'b1; if_a.i_addr = 16'h1234;
        check_fill(0, OWNER_I, 12'h123, 4, "i_fill");
        @(negedge clk);
        check_idle(0, "i_fill_idle");
    endtask

    task automatic test_round_robin();
        logic exp_owner [3];
        exp_owner[0] = OWNER_I; exp_owner[1] = OWNER_D; exp_owner[2] = OWNER_I;
        reset_dut(0);
        for (int r = 0; r < 3; r++) begin
            @(negedge clk);
            check_idle(0, "rr_idle");
            if_a.i_req = 1'b1; if_a.i_addr = 16'h1110;
            if_a.d_req = 1'b1; if_a.d_addr = 16'h2220;
            check_fill(0, exp_owner[r], exp_owner[r] ? 12'h222 : 12'h111, 4, "rr");
            if_a.i_req = 1'b0; if_a.d_req = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        reset_dut(0);
        @(negedge clk);
        if_a.d_wr = 1'b1; if_a.d_req = 1'b1; if_a.i_req = 1'b1;
        if_a.d_addr = 16'h4442; if_a.d_wdata = 16'hBEEF; if_a.i_addr = 16'h2008;
        @(negedge clk);
        sample(0);
        checks += 3;
        if (s_flags !== 8'b0111_0001) begin
            errors++; $display("FAIL write flags got %b want 01110001", s_flags);
        end
        if (s_addr !== 16'h4442) begin
            errors++; $display("FAIL write mem_addr got %h want 4442", s_addr);
        end
        if (s_wdata !== 16'hBEEF) begin
            errors++; $display("FAIL write mem_wdata got %h want beef", s_wdata);
        end
        $display("write: addr=%h data=%h", s_addr, s_wdata);
        if_a.d_wr = 1'b0;
        @(negedge clk);
        check_idle(0, "b2b_idle1");
        check_fill(0, OWNER_I, 12'h200, 4, "b2b_i");
        @(negedge clk);
        check_idle(0, "b2b_idle2");
        check_fill(0, OWNER_D, 12'h444, 4, "b2b_d");
        @(negedge clk);
        check_idle(0, "b2b_idle3");
    endtask

    task automatic test_stray();
        @(negedge clk);
        inj_a = 1'b1;
        #1 check_idle(0, "stray_idle");
        inj_a = 1'b0;
        @(negedge clk);
        if_a.i_req = 1'b1; if_a.i_addr = 16'h0F00;
        check_fill(0, OWNER_I, 12'h0F0, 4, "stray_fill1");
        @(negedge clk);
        inj_a = 1'b1;
        #1 check_idle(0, "ninth_ret");
        inj_a = 1'b0;
        @(negedge clk);
        if_a.i_req = 1'b1; if_a.i_addr = 16'h0E10;
        check_fill(0, OWNER_I, 12'h0E1, 4, "stray_fill2");
        $display("stray: valids outside a fill ignored");
    endtask

    task automatic test_reset_mid_fill();
        @(negedge clk);
        if_a.d_req = 1'b1; if_a.d_addr = 16'h5678;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            sample(0);
            checks++;
            if (s_flags[6] !== 1'b1) begin
                errors++; $display("FAIL mid cyc%0d d_grant got %b want 1", k, s_flags[6]);
            end
            if (k >= 5) begin
                checks += 2;
                if (s_flags[2] !== 1'b1) begin
                    errors++; $display("FAIL mid cyc%0d d_data_valid got %b want 1", k, s_flags[2]);
                end
                if (s_off !== 3'(k - 5)) begin
                    errors++; $display("FAIL mid cyc%0d rd_offset got %0d want %0d", k, s_off, k - 5);
                end
            end
        end
        rst_a = 1'b1;
        @(negedge clk);
        rst_a = 1'b0; if_a.d_req = 1'b0;
        check_idle(0, "mid_rst_idle");
        for (int k = 9; k <= 11; k++) begin
            @(negedge clk);
            check_idle(0, "late_ret");
        end
        $display("reset mid-fill: aborted, late returns ignored");
        @(negedge clk);
        if_a.i_req = 1'b1; if_a.i_addr = 16'h0ABC;
        check_fill(0, OWNER_I, 12'h0AB, 4, "after_rst");
    endtask

    task automatic test_lat1();
        reset_dut(1);
        @(negedge clk);
        if_b.i_req = 1'b1; if_b.i_addr = 16'h3456;
        check_fill(1, OWNER_I, 12'h345, 1, "lat1");
        @(negedge clk);
        check_idle(1, "lat1_idle");
    endtask

    initial begin
        if_a.i_req = 1'b0; if_a.i_addr = '0; if_a.d_req = 1'b0; if_a.d_wr = 1'b0;
        if_a.d_addr = '0; if_a.d_wdata = '0;
        if_b.i_req = 1'b0; if_b.i_addr = '0; if_b.d_req = 1'b0; if_b.d_wr = 1'b0;
        if_b.d_addr = '0; if_b.d_wdata = '0;
        test_reset();
        test_i_fill();
        test_round_robin();
        test_back_to_back();
        test_stray();
        test_reset_mid_fill();
        test_lat1();
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
